// File: rtl/addr_trace_gen.sv
// Address-trace generator for a downstream cache model. It replays a loaded trace,
// sweeps addresses with a fixed stride, or walks a 31-bit LFSR, issuing one address per cycle.
module addr_trace_gen #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned PTR_W = 8
) (
  input  logic        clk_41,
  input  logic        rst_41,
  input  logic        wr_en_41,
  input  logic [30:0] wr_data_41,
  input  logic        start_41,
  input  logic        abort_41,
  input  logic [1:0]  mode_41,
  input  logic [30:0] base_41,
  input  logic [30:0] stride_41,
  input  logic [15:0] count_41,
  output logic [30:0] adder_41,
  output logic        adder_valid_41,
  output logic        busy_41,
  output logic        done_41,
  output logic        full_41,
  output logic [30:0] issued_41
);

  localparam int unsigned AW = 31;
  localparam int unsigned CW = 16;
  localparam int unsigned LW = PTR_W + 1;

  localparam logic [1:0] M_TRACE  = 2'b00;
  localparam logic [1:0] M_STRIDE = 2'b01;
  localparam logic [1:0] M_LFSR   = 2'b10;
  localparam logic [1:0] M_RSVD   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          state;
  logic [AW-1:0]   mem [DEPTH];
  logic [LW-1:0]   length;
  logic [PTR_W-1:0] ridx;
  logic [1:0]      mode_q;
  logic [AW-1:0]   stride_q;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   sent;

  logic            wr_ok_c;
  logic            start_ok_c;
  logic [AW-1:0]   seed_c;

  // Fibonacci LFSR x^31 + x^28 + 1: shift left, feedback from bits 30 and 27 into bit 0
  function automatic logic [AW-1:0] lfsr_step(input logic [AW-1:0] s);
    return {s[AW-2:0], s[30] ^ s[27]};
  endfunction

  // Trace read index advances and wraps back to entry 0 at the loaded length
  function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] idx,
                                                input logic [LW-1:0]    len);
    if (LW'(idx) + LW'(1) >= len) begin
      return '0;
    end
    return idx + PTR_W'(1);
  endfunction

  always_comb begin
    wr_ok_c    = 1'b0;
    start_ok_c = 1'b0;
    seed_c     = base_41;
    if (base_41 == '0) begin
      seed_c = AW'(1);
    end
    if (state == S_IDLE) begin
      wr_ok_c    = wr_en_41 && !full_41;
      start_ok_c = start_41 && !abort_41 && (count_41 != '0) && (mode_41 != M_RSVD) &&
                   ((mode_41 != M_TRACE) || (length != '0));
    end
  end

  // Trace storage has no reset; only the length is cleared
  always_ff @(posedge clk_41) begin
    if (!rst_41 && wr_ok_c) begin
      mem[length[PTR_W-1:0]] <= wr_data_41;
    end
  end

  always_ff @(posedge clk_41) begin
    if (rst_41) begin
      state          <= S_IDLE;
      length         <= '0;
      full_41        <= 1'b0;
      adder_41       <= '0;
      adder_valid_41 <= 1'b0;
      busy_41        <= 1'b0;
      done_41        <= 1'b0;
      issued_41      <= '0;
      ridx           <= '0;
      mode_q         <= M_TRACE;
      stride_q       <= '0;
      count_q        <= '0;
      sent           <= '0;
    end else begin
      if (adder_valid_41) begin
        issued_41 <= issued_41 + AW'(1);
      end
      case (state)
        S_IDLE: begin
          done_41 <= 1'b0;
          if (wr_ok_c) begin
            length  <= length + LW'(1);
            full_41 <= (length + LW'(1) == LW'(DEPTH));
          end
          if (start_ok_c) begin
            state          <= S_RUN;
            busy_41        <= 1'b1;
            adder_valid_41 <= 1'b1;
            issued_41      <= '0;
            mode_q         <= mode_41;
            stride_q       <= stride_41;
            count_q        <= count_41;
            sent           <= CW'(1);
            ridx           <= next_idx(PTR_W'(0), length);
            case (mode_41)
              M_TRACE:  adder_41 <= mem[PTR_W'(0)];
              M_STRIDE: adder_41 <= base_41;
              default:  adder_41 <= seed_c;
            endcase
          end
        end

        S_RUN: begin
          if (abort_41) begin
            state          <= S_IDLE;
            busy_41        <= 1'b0;
            adder_valid_41 <= 1'b0;
          end else if (sent == count_q) begin
            state          <= S_DONE;
            busy_41        <= 1'b0;
            adder_valid_41 <= 1'b0;
            done_41        <= 1'b1;
          end else begin
            sent           <= sent + CW'(1);
            adder_valid_41 <= 1'b1;
            ridx           <= next_idx(ridx, length);
            case (mode_q)
              M_TRACE:  adder_41 <= mem[ridx];
              M_STRIDE: adder_41 <= adder_41 + stride_q;
              M_LFSR:   adder_41 <= lfsr_step(adder_41);
              default:  adder_41 <= adder_41;
            endcase
          end
        end

        S_DONE: begin
          state   <= S_IDLE;
          done_41 <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
